// File: rtl/reg_access_initiator.sv
// Register-bank access initiator: a command FIFO feeds a three-state request engine.
// The engine issues one read or write at a time, applies a timeout, and returns a response.
module reg_access_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] BAD_READ_VALUE = 32'hBADCAFE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_err,
    output logic                  busy,
    output logic                  mem_w_req,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    input  logic                  mem_w_ack,
    output logic                  mem_r_req,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    input  logic                  mem_r_ack
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_BAD     = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t                state;
    logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;
    logic [ENT_W-1:0]      head;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  cur_write;
    logic [TO_W-1:0]       to_cnt;
    logic                  ack_hit;

    assign cmd_ready  = (count != FULL_CNT);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign busy       = (state != IDLE) || (count != '0);
    assign head       = fifo_mem[rd_ptr];
    assign head_write = head[ENT_W-1];
    assign head_addr  = head[ENT_W-2 -: ADDR_WIDTH];
    assign head_data  = head[DATA_WIDTH-1:0];
    // Only the ack matching the issued direction can complete a transaction.
    assign ack_hit    = cur_write ? mem_w_ack : mem_r_ack;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            to_cnt     <= '0;
            cur_write  <= 1'b0;
            mem_w_req  <= 1'b0;
            mem_r_req  <= 1'b0;
            mem_w_addr <= '0;
            mem_r_addr <= '0;
            mem_w_data <= '0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_write <= head_write;
                        to_cnt    <= '0;
                        if (head_write) begin
                            mem_w_req  <= 1'b1;
                            mem_w_addr <= head_addr;
                            mem_w_data <= head_data;
                        end else begin
                            mem_r_req  <= 1'b1;
                            mem_r_addr <= head_addr;
                        end
                        state <= REQ;
                    end
                end
                REQ: begin
                    // An ack on the final counted cycle still wins over the timeout.
                    if (ack_hit) begin
                        mem_w_req <= 1'b0;
                        mem_r_req <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= cur_write;
                        rsp_rdata <= cur_write ? '0 : mem_r_data;
                        rsp_err   <= (!cur_write && (mem_r_data == BAD_READ_VALUE)) ? ERR_BAD : ERR_OK;
                        state     <= RSP;
                    end else if (to_cnt == TO_LAST) begin
                        mem_w_req <= 1'b0;
                        mem_r_req <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= cur_write;
                        rsp_rdata <= '0;
                        rsp_err   <= ERR_TIMEOUT;
                        state     <= RSP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_initiator.sv
// Randomized bench for reg_access_initiator: a behavioural target answers requests with chosen
// latencies, and every issued request and returned response is compared with a queue-based model.
module tb_reg_access_initiator;

    localparam int T = 16;
    localparam logic [31:0] BAD = 32'hBADCAFE;
    localparam int NOACK = 1000;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
    } cmd_t;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  err;
    } rsp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic        cmd_write = 0;
    logic [31:0] cmd_addr = 0;
    logic [31:0] cmd_wdata = 0;
    logic        rsp_valid;
    logic        rsp_ready = 0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        busy;
    logic        mem_w_req;
    logic [31:0] mem_w_data;
    logic [31:0] mem_w_addr;
    logic        mem_w_ack = 0;
    logic        mem_r_req;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_r_data = 0;
    logic        mem_r_ack = 0;

    int   n_pass = 0;
    int   n_total = 0;
    int   rdy_mode = 0;
    logic noise = 0;
    cmd_t iss_q[$];
    rsp_t rsp_q[$];
    cmd_t cur;
    rsp_t last_rsp;
    int   hc = 0;
    logic rsp_seen = 0;

    reg_access_initiator #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(T), .BAD_READ_VALUE(BAD)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .mem_w_req(mem_w_req), .mem_w_data(mem_w_data), .mem_w_addr(mem_w_addr),
        .mem_w_ack(mem_w_ack),
        .mem_r_req(mem_r_req), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
        .mem_r_ack(mem_r_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Register bank contents; bit 8 marks the unmapped region.
    function automatic logic [31:0] target_read(input logic [31:0] a);
        if (a == 32'h14) return 32'h12345678;
        if (a[8]) return BAD;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic int exp_len(input int lat);
        return (lat >= T) ? T : lat + 1;
    endfunction

    function automatic rsp_t model_rsp(input cmd_t c);
        rsp_t r;
        logic to;
        to = (c.lat >= T);
        r.write = c.write;
        r.rdata = (c.write || to) ? 32'h0 : target_read(c.addr);
        r.err   = to ? 2'd1 : ((!c.write && target_read(c.addr) == BAD) ? 2'd2 : 2'd0);
        return r;
    endfunction

    // Target and response monitor, sampling just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            hc = 0;
            rsp_seen = 0;
            mem_w_ack = 0;
            mem_r_ack = 0;
            iss_q.delete();
            rsp_q.delete();
        end else begin
            if (mem_w_req || mem_r_req) begin
                chk("one_req", {mem_w_req, mem_r_req}, mem_w_req ? 2'b10 : 2'b01);
                if (hc == 0) begin
                    if (iss_q.size() == 0) begin
                        chk("issue_unexpected", 1, 0);
                        cur = '{write: mem_w_req, addr: 0, data: 0, lat: NOACK};
                    end else begin
                        cur = iss_q.pop_front();
                        chk("issue_dir", mem_w_req, cur.write);
                        if (cur.write) chk("issue_wdata", mem_w_data, cur.data);
                    end
                end
                chk("req_addr", mem_w_req ? mem_w_addr : mem_r_addr, cur.addr);
                hc++;
                mem_w_ack = mem_w_req ? (hc == cur.lat + 1) : (noise && $urandom_range(1) == 1);
                mem_r_ack = mem_r_req ? (hc == cur.lat + 1) : (noise && $urandom_range(1) == 1);
                mem_r_data = (mem_r_req && mem_r_ack) ? target_read(cur.addr) : $urandom;
            end else begin
                if (hc != 0) chk("req_len", hc, exp_len(cur.lat));
                hc = 0;
                mem_w_ack = 0;
                mem_r_ack = 0;
            end

            if (rsp_valid) begin
                if (!rsp_seen) begin
                    rsp_seen = 1;
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 1, 0);
                        last_rsp = '{write: rsp_write, rdata: rsp_rdata, err: rsp_err};
                    end else begin
                        last_rsp = rsp_q.pop_front();
                        chk("rsp_write", rsp_write, last_rsp.write);
                    end
                end
                chk("rsp_rdata", rsp_rdata, last_rsp.rdata);
                chk("rsp_err", rsp_err, last_rsp.err);
            end else begin
                rsp_seen = 0;
            end

            case (rdy_mode)
                0:       rsp_ready = 1;
                1:       rsp_ready = 0;
                default: rsp_ready = ($urandom_range(1) == 1);
            endcase
        end
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int lat, output int waited);
        cmd_t c;
        @(negedge clk);
        cmd_valid = 1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        waited = 0;
        while (!cmd_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) begin
            chk("cmd_accept_timeout", 1, 0);
            cmd_valid = 0;
        end else begin
            c = '{write: w, addr: a, data: d, lat: lat};
            iss_q.push_back(c);
            rsp_q.push_back(model_rsp(c));
            @(posedge clk);
            #1;
            cmd_valid = 0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((iss_q.size() != 0 || rsp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", n < budget, 1);
    endtask

    initial begin
        int w;
        int n;
        int r;
        int lat;

        repeat (3) @(negedge clk);
        chk("rst_w_req", mem_w_req, 0);
        chk("rst_r_req", mem_r_req, 0);
        chk("rst_w_addr", mem_w_addr, 0);
        chk("rst_r_addr", mem_r_addr, 0);
        chk("rst_w_data", mem_w_data, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_write", rsp_write, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst = 0;
        rdy_mode = 0;
        repeat (2) @(negedge clk);

        // Write with immediate ack: response three edges after acceptance.
        send(1, 32'h10, 32'hDEADBEEF, 1, w);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #2;
            n++;
            if (rsp_valid) break;
        end
        chk("latency", n, 3);
        drain(200);

        send(0, 32'h14, 0, 2, w);
        drain(200);
        send(0, 32'h100, 0, 1, w);
        drain(200);
        send(0, 32'h20, 0, NOACK, w);
        drain(200);
        send(1, 32'h24, 32'h11112222, T - 1, w);
        drain(200);
        send(1, 32'h28, 32'h33334444, T, w);
        drain(200);

        // Five back-to-back commands with the consumer stalled fill the FIFO.
        rdy_mode = 1;
        for (int i = 0; i < 5; i++) begin
            send(i[0], 32'h40 + 4 * i, 32'hA0 + i, 1, w);
            chk("b2b_accept_wait", w, 0);
        end
        @(negedge clk);
        chk("b2b_full", cmd_ready, 0);
        rdy_mode = 0;
        drain(500);

        noise = 1;
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(9);
            if (r <= 6)      lat = 1 + $urandom_range(3);
            else if (r == 7) lat = T - 1;
            else if (r == 8) lat = T;
            else             lat = NOACK;
            repeat ($urandom_range(2)) @(negedge clk);
            send($urandom_range(1) == 1, $urandom & 32'h1FC, $urandom, lat, w);
        end
        drain(5000);
        noise = 0;
        rdy_mode = 0;

        // Reset while a request is pending and more commands are queued.
        send(0, 32'h30, 0, NOACK, w);
        send(1, 32'h34, 32'h55, 1, w);
        send(0, 32'h38, 0, 1, w);
        repeat (3) @(negedge clk);
        chk("pre_rst_req", mem_r_req, 1);
        rst = 1;
        @(posedge clk);
        #2;
        chk("mid_rst_r_req", mem_r_req, 0);
        chk("mid_rst_w_req", mem_w_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", rsp_valid, 0);
            chk("post_rst_req", {mem_w_req, mem_r_req}, 2'b00);
        end

        send(0, 32'h14, 0, 1, w);
        drain(200);
        chk("final_iss_q", iss_q.size(), 0);
        chk("final_rsp_q", rsp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/reg_access_initiator.md
REG_ACCESS_INITIATOR -- requirements
Module: reg_access_initiator

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of the command and memory addresses.
REQ-002 Parameter DATA_WIDTH, default 32, width of the write and read data.
REQ-003 Parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, at least 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, maximum number of request-high cycles without an ack; at least 2.
REQ-005 Parameter BAD_READ_VALUE, default 32'hBADCAFE, read sentinel returned for an unmapped address.
REQ-006 clk  in  1  clock; all logic on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 cmd_valid  in  1  command offered.
REQ-009 cmd_ready  out  1  command FIFO not full.
REQ-010 cmd_write  in  1  1 = write, 0 = read.
REQ-011 cmd_addr  in  ADDR_WIDTH  target byte address.
REQ-012 cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
REQ-013 rsp_valid  out  1  response available.
REQ-014 rsp_ready  in  1  response consumed.
REQ-015 rsp_write  out  1  echo of the command type.
REQ-016 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-017 rsp_err  out  2  0 = OK, 1 = timeout, 2 = bad-address sentinel read.
REQ-018 busy  out  1  state is not IDLE, or the FIFO is non-empty.
REQ-019 mem_w_req / mem_w_data / mem_w_addr  out  1 / DATA_WIDTH / ADDR_WIDTH  write request to the register bank.
REQ-020 mem_w_ack  in  1  write acknowledge.
REQ-021 mem_r_req / mem_r_addr  out  1 / ADDR_WIDTH  read request.
REQ-022 mem_r_data / mem_r_ack  in  DATA_WIDTH / 1  read data (valid in the ack cycle) and read acknowledge.

Function
REQ-023 The FIFO shall push when cmd_valid and cmd_ready are both high; cmd_ready shall equal the FIFO not being full, with no same-cycle bypass.
REQ-024 The FSM shall have exactly three states: IDLE, REQ and RSP.
REQ-025 IDLE with the FIFO non-empty: at the next edge, pop one entry, register its address, data and type, assert exactly one of mem_w_req or mem_r_req, clear the timeout counter, and enter REQ.
REQ-026 REQ: the request, address and data shall be held stable, and the other request shall be held at 0.
REQ-027 REQ with the matching ack high: at that edge, deassert the request and enter RSP.
  - Reads: capture mem_r_data into rsp_rdata.
  - rsp_err = 2 if it is a read and mem_r_data equals BAD_READ_VALUE; otherwise 0.
REQ-028 The ack of the non-issued direction shall be ignored.
REQ-029 REQ with no ack: the counter shall increment each cycle.
  - On the edge where the counter equals TIMEOUT_CYCLES-1 and there is still no ack: deassert the request, set rsp_err = 1 and rsp_rdata = 0, and enter RSP.
  - The request shall therefore be high for exactly TIMEOUT_CYCLES cycles.
REQ-030 An ack in the same cycle as the timeout condition shall take priority over the timeout, and the response is OK or bad-address.
REQ-031 RSP: rsp_valid shall be high and all rsp_* outputs shall be stable until rsp_ready is high; at that edge, clear rsp_valid and enter IDLE.
REQ-032 Only one transaction shall be outstanding at a time.
REQ-033 A new request shall not be issued earlier than the edge after the response handshake.
REQ-034 Latency: with an immediate ack (target acks one cycle after seeing the request) and rsp_ready held high, rsp_valid shall rise 3 cycles after the edge that accepted the command into an empty idle block.
REQ-035 Commands shall be issued in FIFO order.
REQ-036 The FIFO pointers shall wrap modulo FIFO_DEPTH.
REQ-037 A push and a pop in the same cycle shall leave the count unchanged.

Reset
REQ-038 While rst is high, at each edge the following shall be forced:
  - State IDLE, FIFO empty, and the timeout counter 0.
  - mem_w_req = 0, mem_r_req = 0, mem_w_addr = 0, mem_r_addr = 0, mem_w_data = 0.
  - rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, cmd_ready = 1.
REQ-039 A reset asserted mid-transaction (in REQ or RSP) shall abandon the transaction and discard queued commands, with no response produced.

Verification
REQ-040 Write 0x10 with data 0xDEADBEEF to a compliant target, rsp_ready = 1 -> mem_w_req is high 2 cycles; rsp_valid is high 3 cycles after acceptance with rsp_write = 1 and rsp_err = 0.
REQ-041 Read 0x14, where the target returns 0x12345678 -> rsp_rdata = 0x12345678, rsp_err = 0, and mem_w_req stays 0 throughout.
REQ-042 Read to an unmapped address, where the target returns 0xBADCAFE -> rsp_err = 2 and rsp_rdata = 0xBADCAFE.
REQ-043 Target never acks, TIMEOUT_CYCLES = 16 -> the request is high exactly 16 cycles, then rsp_err = 1 and rsp_rdata = 0.
REQ-044 Push 5 commands back-to-back with rsp_ready = 0 -> cmd_ready drops after 5 accepted (4 queued plus 1 issued); releasing rsp_ready completes all 5 in order.
REQ-045 Assert rst for one cycle while in REQ -> the request is 0 the next cycle, the FIFO is empty, no rsp_valid pulse occurs, and cmd_ready = 1.
